uart_xmit_arbiter: RTL and testbench



---
 rtl/uart_pkg.sv | 15 +
 rtl/rr_pick.sv | 38 +++
 rtl/uart_xmit_arbiter.sv | 165 ++++++++++++++++
 tb/tb_uart_xmit_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter FSM state encoding and the byte driven onto
// the transmitter data bus while nothing is granted.
package uart_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE      = 3'd0,
        ARB_LAUNCH    = 3'd1,
        ARB_WAIT_BUSY = 3'd2,
        ARB_WAIT_DONE = 3'd3,
        ARB_GAP       = 3'd4
    } arb_state_t;

    localparam logic [7:0] UART_IDLE_BYTE = 8'h00;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: returns the first set request bit
// at or after ptr, wrapping past the top back to bit 0.
module rr_pick #(
    parameter int  NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            valid,
    output logic [IW-1:0]   idx
);

    logic [NREQ-1:0] upper_mask;
    logic [NREQ-1:0] upper_req;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_mask
            assign upper_mask[gi] = (gi >= int'(ptr));
        end
    endgenerate

    assign upper_req = req & upper_mask;
    assign valid     = |req;

    // Lowest set bit of the masked vector wins; fall back to the whole vector
    // when nothing at or above ptr is requesting (the wrap case).
    always_comb begin
        idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) idx = IW'(i);
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (upper_req[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/uart_xmit_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between NREQ requesters,
// with a per-wait-state timeout abort and an enforced idle gap between frames.
module uart_xmit_arbiter
    import uart_pkg::*;
#(
    parameter int  NREQ    = 4,
    parameter int  TO_CYC  = 1023,
    parameter int  GAP_CYC = 2,
    localparam int IW      = $clog2(NREQ),
    localparam int TW      = $clog2(TO_CYC + 1),
    localparam int GW      = $clog2(GAP_CYC + 1)
) (
    input  logic              sys_clk,
    input  logic              sys_rst_l,
    input  logic [NREQ-1:0]   req_i,
    input  logic [8*NREQ-1:0] req_data_i,
    output logic [NREQ-1:0]   ack_o,
    output logic [NREQ-1:0]   nak_o,
    output logic              xmitH,
    output logic [7:0]        xmit_dataH,
    input  logic              xmit_doneH,
    output logic              busy_o,
    output logic [IW-1:0]     grant_id_o,
    output logic              timeout_o
);

    arb_state_t      state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [7:0]      data_q, data_d;
    logic            xmit_q, xmit_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [NREQ-1:0] nak_q, nak_d;
    logic            busy_q, busy_d;
    logic            timeout_q, timeout_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;

    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic [7:0]      req_bytes [NREQ];
    logic [NREQ-1:0] grant_onehot;
    logic [IW-1:0]   next_ptr;
    logic            to_expired;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_bytes
            assign req_bytes[gi] = req_data_i[8*gi +: 8];
        end
    endgenerate

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req   (req_i),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign grant_onehot = {{(NREQ-1){1'b0}}, 1'b1} << grant_q;
    assign next_ptr     = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + IW'(1);
    assign to_expired   = (to_cnt_q == TW'(TO_CYC));

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        data_d    = data_q;
        xmit_d    = 1'b0;
        ack_d     = '0;
        nak_d     = '0;
        timeout_d = timeout_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid && xmit_doneH) begin
                    grant_d = pick_idx;
                    data_d  = req_bytes[pick_idx];
                    xmit_d  = 1'b1;
                    state_d = ARB_LAUNCH;
                end
            end
            ARB_LAUNCH: state_d = ARB_WAIT_BUSY;
            ARB_WAIT_BUSY: begin
                if (!xmit_doneH) begin
                    state_d = ARB_WAIT_DONE;
                end else if (to_expired) begin
                    nak_d     = grant_onehot;
                    timeout_d = 1'b1;
                    rr_ptr_d  = next_ptr;
                    state_d   = ARB_GAP;
                end
            end
            ARB_WAIT_DONE: begin
                if (xmit_doneH) begin
                    ack_d    = grant_onehot;
                    rr_ptr_d = next_ptr;
                    state_d  = ARB_GAP;
                end else if (to_expired) begin
                    nak_d     = grant_onehot;
                    timeout_d = 1'b1;
                    rr_ptr_d  = next_ptr;
                    state_d   = ARB_GAP;
                end
            end
            ARB_GAP: begin
                if (gap_cnt_q == GW'(GAP_CYC)) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Both counters restart on every state change, so each wait state gets its
    // own full TO_CYC budget.
    always_comb begin
        to_cnt_d  = '0;
        gap_cnt_d = '0;
        if (state_d == state_q) begin
            if (state_q == ARB_WAIT_BUSY || state_q == ARB_WAIT_DONE) begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
            if (state_q == ARB_GAP) begin
                gap_cnt_d = gap_cnt_q + GW'(1);
            end
        end
    end

    assign busy_d = (state_d != ARB_IDLE);

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            state_q   <= ARB_IDLE;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            data_q    <= UART_IDLE_BYTE;
            xmit_q    <= 1'b0;
            ack_q     <= '0;
            nak_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            to_cnt_q  <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            data_q    <= data_d;
            xmit_q    <= xmit_d;
            ack_q     <= ack_d;
            nak_q     <= nak_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            to_cnt_q  <= to_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign ack_o      = ack_q;
    assign nak_o      = nak_q;
    assign xmitH      = xmit_q;
    assign xmit_dataH = data_q;
    assign busy_o     = busy_q;
    assign grant_id_o = grant_q;
    assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_uart_xmit_arbiter.sv
// Randomised bench for uart_xmit_arbiter: a transaction-level scheduler model and
// a behavioural transmitter, plus a second instance with a short timeout.
module tb_uart_xmit_arbiter;

    localparam int NREQ      = 4;
    localparam int GAP_CYC   = 2;
    localparam int TO_SHORT  = 15;
    localparam int FRAME_CYC = 160;

    logic        sys_clk = 1'b0;
    logic        sys_rst_l = 1'b1;
    always #5 sys_clk = ~sys_clk;

    logic [3:0]  req_i;
    logic [31:0] req_data_i;
    logic [3:0]  ack_o, nak_o;
    logic        xmitH;
    logic [7:0]  xmit_dataH;
    logic        xmit_doneH;
    logic        busy_o;
    logic [1:0]  grant_id_o;
    logic        timeout_o;

    logic [3:0]  req2;
    logic [31:0] data2;
    logic [3:0]  ack2, nak2;
    logic        xmit2;
    logic [7:0]  xd2;
    logic        done2;
    logic        busy2;
    logic [1:0]  gid2;
    logic        to2;

    uart_xmit_arbiter #(.NREQ(NREQ), .TO_CYC(1023), .GAP_CYC(GAP_CYC)) dut (
        .sys_clk(sys_clk), .sys_rst_l(sys_rst_l), .req_i(req_i), .req_data_i(req_data_i),
        .ack_o(ack_o), .nak_o(nak_o), .xmitH(xmitH), .xmit_dataH(xmit_dataH),
        .xmit_doneH(xmit_doneH), .busy_o(busy_o), .grant_id_o(grant_id_o), .timeout_o(timeout_o)
    );

    uart_xmit_arbiter #(.NREQ(NREQ), .TO_CYC(TO_SHORT), .GAP_CYC(GAP_CYC)) dut_to (
        .sys_clk(sys_clk), .sys_rst_l(sys_rst_l), .req_i(req2), .req_data_i(data2),
        .ack_o(ack2), .nak_o(nak2), .xmitH(xmit2), .xmit_dataH(xd2),
        .xmit_doneH(done2), .busy_o(busy2), .grant_id_o(gid2), .timeout_o(to2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // scheduler model
    int cyc = 0;
    int rr_m = 0;
    bit frame_on = 0;
    int cur_g = 0;
    int launch_at = 0;
    bit saw_low = 0;
    int last_end = -100;
    int n_ack = 0;
    int n_launch = 0;
    logic [3:0] last_ack_val = '0;
    int log_g[$];
    int log_d[$];
    bit auto_req = 0;

    // transmitter model
    bit tx_level = 1;
    bit tx_force_low = 0;
    int tx_fall_at = -1;
    int tx_rise_at = -1;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pick_m(input logic [3:0] r, input int p);
        for (int i = 0; i < NREQ; i++) begin
            if (r[(p + i) % NREQ]) return (p + i) % NREQ;
        end
        return -1;
    endfunction

    task automatic tick();
        logic [3:0]  pr;
        logic [31:0] pd;
        logic        pdn, prs;
        bit          exp_l, exp_a;
        int          g;
        pr  = req_i;
        pd  = req_data_i;
        pdn = xmit_doneH;
        prs = sys_rst_l;
        @(posedge sys_clk);
        #1;
        cyc++;
        if (prs && sys_rst_l) begin
            if (xmitH) n_launch++;
            exp_l = !frame_on && (cyc - 1 >= last_end + GAP_CYC + 1) && pdn && (pr != 4'b0);
            if (exp_l || xmitH) begin
                chk_eq("launch", {31'b0, xmitH}, {31'b0, exp_l});
                if (exp_l) begin
                    g = pick_m(pr, rr_m);
                    chk_eq("grant", {30'b0, grant_id_o}, g);
                    chk_eq("data", {24'b0, xmit_dataH}, {24'b0, pd[8*g +: 8]});
                    log_g.push_back(int'(grant_id_o));
                    log_d.push_back(int'(xmit_dataH));
                    frame_on  = 1;
                    cur_g     = g;
                    launch_at = cyc;
                    saw_low   = 0;
                end
            end
            exp_a = frame_on && saw_low && pdn && (cyc >= launch_at + 2);
            if (frame_on && (cyc >= launch_at + 2) && !pdn) saw_low = 1;
            if (exp_a || ack_o != 4'b0) begin
                chk_eq("ack", {28'b0, ack_o}, exp_a ? (32'd1 << cur_g) : 32'd0);
                if (exp_a) begin
                    frame_on     = 0;
                    rr_m         = (cur_g + 1) % NREQ;
                    last_end     = cyc;
                    last_ack_val = ack_o;
                    n_ack++;
                end
            end
            if (nak_o != 4'b0) chk_eq("nak_unexpected", {28'b0, nak_o}, 0);
        end
        if (xmitH && sys_rst_l) begin
            tx_fall_at = cyc + int'($urandom_range(2, 3));
            tx_rise_at = tx_fall_at + FRAME_CYC;
        end
        if (cyc == tx_fall_at) tx_level = 0;
        if (cyc == tx_rise_at) tx_level = 1;
        xmit_doneH = tx_force_low ? 1'b0 : tx_level;
        if (auto_req) begin
            for (int k = 0; k < NREQ; k++) begin
                if (ack_o[k]) begin
                    req_i[k] = 1'b0;
                end else if (!req_i[k] && $urandom_range(0, 5) == 0) begin
                    req_data_i[8*k +: 8] = 8'($urandom);
                    req_i[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic apply_reset();
        sys_rst_l = 1'b0;
        #1;
        chk_eq("rst_xmit", {31'b0, xmitH}, 0);
        chk_eq("rst_data", {24'b0, xmit_dataH}, 0);
        chk_eq("rst_grant", {30'b0, grant_id_o}, 0);
        chk_eq("rst_busy", {31'b0, busy_o}, 0);
        chk_eq("rst_timeout", {31'b0, timeout_o}, 0);
        chk_eq("rst_acknak", {24'b0, ack_o, nak_o}, 0);
        chk_eq("rst_to_flag", {31'b0, to2}, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_eq("rst_hold_acknak", {24'b0, ack_o, nak_o}, 0);
        end
        sys_rst_l = 1'b1;
        rr_m     = 0;
        frame_on = 0;
        last_end = cyc - GAP_CYC - 2;
    endtask

    task automatic wait_acks(input int target, input int budget, input string tag);
        int b;
        b = budget;
        while (n_ack < target && b > 0) begin
            tick();
            b--;
        end
        chk_eq(tag, n_ack, target);
    endtask

    task automatic dead_test();
        int t_l, t_n;
        req2  = 4'b0011;
        data2 = $urandom;
        for (int f = 0; f < 2; f++) begin
            t_l = -1;
            t_n = -1;
            for (int i = 0; i < 200 && t_n < 0; i++) begin
                tick();
                if (xmit2 && t_l < 0) begin
                    t_l = cyc;
                    chk_eq("dead_grant", {30'b0, gid2}, f);
                    chk_eq("dead_data", {24'b0, xd2}, {24'b0, data2[8*f +: 8]});
                    chk_eq("dead_busy", {31'b0, busy2}, 1);
                    chk_eq("dead_flag_pre", {31'b0, to2}, (f == 0) ? 0 : 1);
                end
                if (ack2 != 4'b0) chk_eq("dead_ack", {28'b0, ack2}, 0);
                if (nak2 != 4'b0) begin
                    t_n = cyc;
                    chk_eq("dead_nak", {28'b0, nak2}, 32'd1 << f);
                end
            end
            chk_eq("dead_nak_latency", t_n - t_l, TO_SHORT + 2);
            chk_eq("dead_flag", {31'b0, to2}, 1);
        end
        req2 = 4'b0;
    endtask

    initial begin
        int base, acks0, launches0, b;
        logic [31:0] bytes;
        req_i = '0; req_data_i = '0; xmit_doneH = 1'b1;
        req2 = '0; data2 = '0; done2 = 1'b1;
        #2;
        apply_reset();

        // single request from requester 2
        req_data_i = $urandom;
        req_data_i[23:16] = 8'hA5;
        req_i = 4'b0100;
        launches0 = n_launch;
        wait_acks(n_ack + 1, 400, "single_done");
        req_i = 4'b0;
        chk_eq("single_launches", n_launch - launches0, 1);
        chk_eq("single_grant", log_g[log_g.size()-1], 2);
        chk_eq("single_data", log_d[log_d.size()-1], 32'hA5);
        chk_eq("single_ack", {28'b0, last_ack_val}, 4'b0100);
        chk_eq("single_grant_hold", {30'b0, grant_id_o}, 2);
        // pointer now at 3: of {0,1,3} requester 3 goes first
        req_data_i = $urandom;
        req_i = 4'b1011;
        wait_acks(n_ack + 1, 400, "ptr3_done");
        req_i = 4'b0;
        chk_eq("ptr3_grant", log_g[log_g.size()-1], 3);

        // round robin with all requesters held
        apply_reset();
        bytes = $urandom;
        req_data_i = bytes;
        req_i = 4'b1111;
        base = log_g.size();
        wait_acks(n_ack + 8, 8 * 400, "rr_done");
        req_i = 4'b0;
        for (int i = 0; i < 8; i++) begin
            chk_eq("rr_order", log_g[base+i], i % 4);
            chk_eq("rr_byte", log_d[base+i], {24'b0, bytes[8*(i%4) +: 8]});
        end

        // transmitter reports busy: no grant until it goes idle
        tx_force_low = 1;
        tick();
        req_data_i = $urandom;
        req_i = 4'b0001;
        launches0 = n_launch;
        repeat (30) tick();
        chk_eq("busy_no_launch", n_launch - launches0, 0);
        tx_force_low = 0;
        xmit_doneH = tx_level;
        tick();
        chk_eq("busy_launch_latency", {31'b0, xmitH}, 1);
        wait_acks(n_ack + 1, 400, "busy_done");
        req_i = 4'b0;

        // requester 1 withdraws mid-frame
        req_data_i = $urandom;
        req_i = 4'b0010;
        b = 0;
        while (tx_level && b < 40) begin tick(); b++; end
        repeat (5) tick();
        req_i[1] = 1'b0;
        wait_acks(n_ack + 1, 400, "withdraw_done");
        chk_eq("withdraw_ack", {28'b0, last_ack_val}, 4'b0010);

        // reset during WAIT_DONE, then a fresh request starts from requester 0
        req_data_i = $urandom;
        req_i = 4'b0100;
        b = 0;
        while (tx_level && b < 40) begin tick(); b++; end
        repeat (10) tick();
        chk_eq("midrst_busy_before", {31'b0, busy_o}, 1);
        acks0 = n_ack;
        req_i = 4'b0;
        apply_reset();
        req_data_i = $urandom;
        req_i = 4'b0101;
        wait_acks(acks0 + 1, 400, "midrst_fresh_done");
        req_i = 4'b0;
        chk_eq("midrst_fresh_grant", log_g[log_g.size()-1], 0);

        // random traffic against the model
        auto_req = 1;
        wait_acks(n_ack + 20, 20 * 500, "random_done");
        auto_req = 0;
        req_i = 4'b0;
        b = 0;
        while (frame_on && b < 400) begin tick(); b++; end
        chk_eq("random_drain", {31'b0, frame_on}, 0);
        chk_eq("no_timeout_normal", {31'b0, timeout_o}, 0);

        // dead transmitter on the short-timeout instance
        dead_test();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
